// File: rtl/indirect_csr_ctrl.sv
// Host CSR block with an indirect-access bridge to a target bus.
// One outstanding target request at a time, bounded by a cycle timeout.
module indirect_csr_ctrl #(
  parameter logic [63:0] DFH_VALUE = 64'h3_00000_001000_0020,
  parameter int unsigned TGT_AW    = 20,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_wr,
  input  logic              csr_rd,
  input  logic [11:0]       csr_addr,
  input  logic [63:0]       csr_wdata,
  output logic [63:0]       csr_rdata,
  output logic              csr_rvalid,
  output logic              tgt_req,
  output logic              tgt_we,
  output logic [TGT_AW-1:0] tgt_addr,
  output logic [63:0]       tgt_wdata,
  input  logic              tgt_ack,
  input  logic [63:0]       tgt_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [8:0] A_DFH   = 9'h000;
  localparam logic [8:0] A_SCR   = 9'h001;
  localparam logic [8:0] A_STAT  = 9'h002;
  localparam logic [8:0] A_ADDR  = 9'h003;
  localparam logic [8:0] A_WDATA = 9'h004;
  localparam logic [8:0] A_CMD   = 9'h005;
  localparam logic [8:0] A_RDATA = 9'h006;

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [63:0]       scratch, ind_wdata, ind_rdata, rd_mux;
  logic [TGT_AW-1:0] ind_addr;
  logic              busy, done, tmo_err, cmd_err;
  logic              start, complete, expire, cmd_err_set;
  logic [8:0]        word;
  logic              wr_scr, wr_stat, wr_addr, wr_wdata, wr_cmd, cmd_valid;
  logic              unused;

  assign word      = csr_addr[11:3];
  assign unused    = ^csr_addr[2:0];
  assign wr_scr    = csr_wr && (word == A_SCR);
  assign wr_stat   = csr_wr && (word == A_STAT);
  assign wr_addr   = csr_wr && (word == A_ADDR);
  assign wr_wdata  = csr_wr && (word == A_WDATA);
  assign wr_cmd    = csr_wr && (word == A_CMD);
  assign cmd_valid = csr_wdata[0] ^ csr_wdata[1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus one-cycle event strobes; expiry loses to a same-cycle ack.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    complete    = 1'b0;
    expire      = 1'b0;
    cmd_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (wr_cmd) begin
          if (cmd_valid) begin
            start      = 1'b1;
            state_next = REQ;
          end else begin
            cmd_err_set = 1'b1;
          end
        end
      end
      REQ: begin
        if (wr_cmd || wr_addr || wr_wdata) cmd_err_set = 1'b1;
        if (tgt_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      A_DFH:   rd_mux = DFH_VALUE;
      A_SCR:   rd_mux = scratch;
      A_STAT:  rd_mux = {60'd0, cmd_err, tmo_err, done, busy};
      A_ADDR:  rd_mux = 64'(ind_addr);
      A_WDATA: rd_mux = ind_wdata;
      A_RDATA: rd_mux = ind_rdata;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      tgt_req    <= 1'b0;
      tgt_we     <= 1'b0;
      tgt_addr   <= '0;
      tgt_wdata  <= '0;
      scratch    <= '0;
      ind_addr   <= '0;
      ind_wdata  <= '0;
      ind_rdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tmo_err    <= 1'b0;
      cmd_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      csr_rvalid <= csr_rd;
      csr_rdata  <= csr_rd ? rd_mux : '0;
      tgt_req    <= (state_next == REQ);
      if (wr_scr) scratch <= csr_wdata;
      if (state == IDLE && wr_addr)  ind_addr  <= csr_wdata[TGT_AW-1:0];
      if (state == IDLE && wr_wdata) ind_wdata <= csr_wdata;
      if (wr_stat) begin
        if (csr_wdata[2]) tmo_err <= 1'b0;
        if (csr_wdata[3]) cmd_err <= 1'b0;
      end
      if (cmd_err_set) cmd_err <= 1'b1;
      if (start) begin
        tgt_addr  <= ind_addr;
        tgt_we    <= csr_wdata[1];
        tgt_wdata <= ind_wdata;
        busy      <= 1'b1;
        done      <= 1'b0;
        tmo_err   <= 1'b0;
        cmd_err   <= 1'b0;
        cnt       <= '0;
      end else if (state == REQ && !tgt_ack && cnt != CW'(TIMEOUT)) begin
        cnt <= cnt + CW'(1);
      end
      if (complete) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (!tgt_we) ind_rdata <= tgt_rdata;
      end
      if (expire) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        tmo_err <= 1'b1;
        if (!tgt_we) ind_rdata <= '1;
      end
    end
  end

endmodule

// File: tb/tb_indirect_csr_ctrl.sv
// Randomized scoreboard bench for indirect_csr_ctrl against a register-level
// reference model; host read responses are checked by an independent monitor.
module tb_indirect_csr_ctrl;

  localparam int unsigned TO = 32;
  localparam int unsigned AW = 20;
  localparam logic [63:0] DFH = 64'h3_00000_001000_0020;

  logic          clk, rst, csr_wr, csr_rd, csr_rvalid, tgt_req, tgt_we, tgt_ack;
  logic [11:0]   csr_addr;
  logic [63:0]   csr_wdata, csr_rdata, tgt_wdata, tgt_rdata;
  logic [AW-1:0] tgt_addr;

  indirect_csr_ctrl #(.DFH_VALUE(DFH), .TGT_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
    .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents only.
  logic [63:0]   m_scr, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  bit            m_busy, m_done, m_tmo, m_cerr;
  logic [63:0]   exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_reset;
    m_scr = '0; m_wdata = '0; m_rdata = '0; m_addr = '0;
    m_busy = 0; m_done = 0; m_tmo = 0; m_cerr = 0;
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    logic [11:0] w;
    w = {a[11:3], 3'b000};
    case (w)
      12'h000: return DFH;
      12'h008: return m_scr;
      12'h010: return {60'd0, m_cerr, m_tmo, m_done, m_busy};
      12'h018: return 64'(m_addr);
      12'h020: return m_wdata;
      12'h030: return m_rdata;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [63:0] d);
    logic [11:0] w;
    w = {a[11:3], 3'b000};
    case (w)
      12'h008: m_scr = d;
      12'h010: begin
        if (d[2]) m_tmo = 0;
        if (d[3]) m_cerr = 0;
      end
      12'h018: if (m_busy) m_cerr = 1; else m_addr = d[AW-1:0];
      12'h020: if (m_busy) m_cerr = 1; else m_wdata = d;
      12'h028: begin
        if (m_busy) m_cerr = 1;
        else if (d[0] ^ d[1]) begin
          m_busy = 1; m_done = 0; m_tmo = 0; m_cerr = 0;
        end else m_cerr = 1;
      end
      default: ;
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csr_wr = 1; csr_addr = a; csr_wdata = d;
    tick;
    csr_wr = 0;
  endtask

  task automatic csr_read(input logic [11:0] a);
    exp_q.push_back(model_read(a));
    csr_rd = 1; csr_addr = a;
    tick;
    csr_rd = 0;
    chk("csr_rvalid", 64'(csr_rvalid), 64'd1);
  endtask

  // Scoreboard monitor: every host response must match the oldest expectation.
  always @(negedge clk) begin
    if (csr_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rvalid: got rdata %h, required no response", csr_rdata);
      end else begin
        chk("csr_rdata", csr_rdata, exp_q.pop_front());
      end
    end
  end

  // Issue one indirect op; delay < 0 or >= TO means the target never acks.
  task automatic run_op(input bit is_wr, input int delay, input logic [63:0] rd, input bit poke);
    int n, exp_n;
    logic [AW-1:0] a0;
    logic [63:0] cmd;
    a0  = m_addr;
    cmd = ({$urandom, $urandom} & ~64'h3) | (is_wr ? 64'd2 : 64'd1);
    chk("tgt_req_idle", 64'(tgt_req), 64'd0);
    model_write(12'h028, cmd);
    csr_write(12'h028, cmd);
    chk("tgt_req_rise", 64'(tgt_req), 64'd1);
    chk("tgt_we", 64'(tgt_we), 64'(is_wr));
    chk("tgt_addr", 64'(tgt_addr), 64'(m_addr));
    chk("tgt_wdata", tgt_wdata, m_wdata);
    n = 0;
    while (tgt_req === 1'b1 && n < int'(TO) + 8) begin
      if (n == delay) begin
        tgt_ack = 1; tgt_rdata = rd;
      end else tgt_rdata = {$urandom, $urandom};
      if (n == 1) begin
        exp_q.push_back(model_read(12'h010));
        csr_rd = 1; csr_addr = 12'h010;
      end
      if (n == 2 && poke) begin
        model_write(12'h018, 64'h3);
        csr_wr = 1; csr_addr = 12'h018; csr_wdata = 64'h3;
      end
      tick;
      tgt_ack = 0; csr_rd = 0; csr_wr = 0;
      n++;
    end
    exp_n = (delay >= 0 && delay < int'(TO)) ? delay + 1 : int'(TO);
    chk("req_cycles", 64'(n), 64'(exp_n));
    chk("tgt_addr_hold", 64'(tgt_addr), 64'(a0));
    m_busy = 0; m_done = 1;
    if (delay >= 0 && delay < int'(TO)) begin
      if (!is_wr) m_rdata = rd;
    end else begin
      m_tmo = 1;
      if (!is_wr) m_rdata = '1;
    end
    // A stray ack while idle must change nothing.
    tgt_ack = 1; tgt_rdata = {$urandom, $urandom};
    tick;
    tgt_ack = 0;
    chk("tgt_req_after", 64'(tgt_req), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [11:0] a;
    int delay;
    rst = 1; csr_wr = 0; csr_rd = 0; csr_addr = '0; csr_wdata = '0;
    tgt_ack = 0; tgt_rdata = '0;
    model_reset();
    repeat (3) tick;
    chk("rst_rvalid", 64'(csr_rvalid), 64'd0);
    chk("rst_rdata", csr_rdata, 64'd0);
    chk("rst_tgt_req", 64'(tgt_req), 64'd0);
    chk("rst_tgt_bus", {tgt_wdata[62:0], tgt_we}, 64'd0);
    chk("rst_tgt_addr", 64'(tgt_addr), 64'd0);
    rst = 0;
    tick;

    csr_read(12'h000);
    csr_write(12'h008, 64'hDEAD_BEEF_0123_4567); model_write(12'h008, 64'hDEAD_BEEF_0123_4567);
    csr_read(12'h008);
    csr_read(12'hFF8);
    csr_read(12'h028);

    // Malformed command while idle.
    csr_write(12'h028, 64'h3); model_write(12'h028, 64'h3);
    chk("bad_cmd_no_req", 64'(tgt_req), 64'd0);
    csr_read(12'h010);

    // Read with ack three cycles after request.
    csr_write(12'h018, 64'h10); model_write(12'h018, 64'h10);
    run_op(1'b0, 3, 64'hA5A5, 1'b0);
    csr_read(12'h030);
    csr_read(12'h010);

    // Write with an IND_ADDR write while busy.
    run_op(1'b1, 5, 64'h0, 1'b1);
    csr_read(12'h010);
    csr_read(12'h018);

    // Write that times out, then clear timeout_err.
    csr_write(12'h020, 64'h55); model_write(12'h020, 64'h55);
    run_op(1'b1, -1, 64'h0, 1'b0);
    csr_read(12'h010);
    csr_write(12'h010, 64'h4); model_write(12'h010, 64'h4);
    csr_read(12'h010);

    // Ack landing exactly in the expiry cycle.
    run_op(1'b0, int'(TO) - 1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    csr_read(12'h010);
    csr_read(12'h030);

    // Read that times out loads all-ones.
    run_op(1'b0, -1, 64'h0, 1'b0);
    csr_read(12'h030);

    for (int it = 0; it < 40; it++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: begin
          csr_write(12'h008, d); model_write(12'h008, d);
          csr_read(12'h008 | 12'($urandom_range(0, 7)));
        end
        1: begin
          a = $urandom_range(0, 1) ? 12'h018 : 12'h020;
          csr_write(a, d); model_write(a, d);
          csr_read(a);
        end
        2: begin
          case ($urandom_range(0, 9))
            0: delay = -1;
            1: delay = int'(TO) - 1;
            default: delay = int'($urandom_range(0, 8));
          endcase
          run_op(1'($urandom_range(0, 1)), delay, d, 1'($urandom_range(0, 1)));
          csr_read(12'h010);
          csr_read(12'h030);
        end
        3: begin
          d[1:0] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
          csr_write(12'h028, d); model_write(12'h028, d);
          chk("bad_cmd_no_req", 64'(tgt_req), 64'd0);
          csr_read(12'h010);
        end
        4: begin
          csr_write(12'h010, d); model_write(12'h010, d);
          csr_read(12'h010);
        end
        default: begin
          a = 12'($urandom_range(0, 4095));
          if (a[11:3] != 9'h005) begin
            csr_write(a, d); model_write(a, d);
          end
          csr_read(a);
          csr_read(12'($urandom_range(0, 4095)));
        end
      endcase
    end

    // Reset two cycles into a pending read, then a stale ack.
    csr_write(12'h028, 64'h1); model_write(12'h028, 64'h1);
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0;
    model_reset();
    chk("rst_req_drop", 64'(tgt_req), 64'd0);
    chk("rst_req_addr", 64'(tgt_addr), 64'd0);
    tgt_ack = 1; tgt_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick;
    tgt_ack = 0;
    tick;
    chk("stale_ack_req", 64'(tgt_req), 64'd0);
    csr_read(12'h010);
    csr_read(12'h030);
    csr_read(12'h008);

    repeat (3) tick;
    chk("pending_responses", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/indirect_csr_ctrl.md
INDIRECT_CSR_CTRL -- requirements
Module: indirect_csr_ctrl

Interface
REQ-001 SHALL have parameter DFH_VALUE, default 64'h3_00000_001000_0020, the value returned at offset 0x000.
REQ-002 SHALL have parameter TGT_AW, default 20, the target address width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the number of cycles tgt_req may stay high without tgt_ack.
REQ-004 SHALL have clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have csr_wr / csr_rd, input, 1 each: host write / read strobes, one-cycle pulses, never both high together.
REQ-007 SHALL have csr_addr, input, 12: host byte address, 8-byte aligned; bits [2:0] are ignored.
REQ-008 SHALL have csr_wdata, input, 64: host write data.
REQ-009 SHALL have csr_rdata, output, 64, and csr_rvalid, output, 1: host read response.
REQ-010 SHALL have tgt_req, output, 1, and tgt_we, output, 1: target request and write-enable (1 = write).
REQ-011 SHALL have tgt_addr, output, TGT_AW, and tgt_wdata, output, 64: target address and write data.
REQ-012 SHALL have tgt_ack, input, 1, and tgt_rdata, input, 64: target one-cycle completion and read data, valid with tgt_ack.

Function
REQ-013 SHALL decode the register map as follows:
  - 0x000 DFH: read-only, returns DFH_VALUE.
  - 0x008 SCRATCHPAD: read/write, 64 bits.
  - 0x010 STAT: bit0 busy, bit1 done, bit2 timeout_err, bit3 cmd_err; other bits read 0.
  - 0x018 IND_ADDR: read/write, [TGT_AW-1:0].
  - 0x020 IND_WDATA: read/write, 64 bits.
  - 0x028 IND_CMD: write-only, reads 0; bit0 = start read, bit1 = start write.
  - 0x030 IND_RDATA: read-only.
  - 0xFF8 and all unmapped offsets: read 0, writes ignored.
REQ-014 SHALL return host read data with csr_rvalid one cycle after csr_rd, lasting one cycle.
REQ-015 SHALL return pre-update register values on a host read in the same cycle as a register update.
REQ-016 SHALL implement an FSM with states IDLE and REQ.
REQ-017 SHALL move IDLE to REQ when IND_CMD is written with exactly one of bit0/bit1 set:
  - tgt_req rises the next cycle.
  - tgt_addr, tgt_we and tgt_wdata are latched from IND_ADDR, bit1 and IND_WDATA.
  - done, timeout_err and cmd_err clear; busy sets.
REQ-018 SHALL hold tgt_req and the latched tgt_addr, tgt_we and tgt_wdata stable in REQ until completion.
REQ-019 SHALL complete on tgt_ack sampled high in REQ:
  - tgt_req falls the next cycle; state returns to IDLE.
  - busy clears and done sets.
  - For a read, IND_RDATA captures tgt_rdata.
REQ-020 SHALL ignore tgt_ack in IDLE.
REQ-021 SHALL count REQ cycles without ack in a saturating counter cleared on entry to REQ.
REQ-022 SHALL, after TIMEOUT consecutive REQ cycles without ack:
  - drop tgt_req the next cycle and return to IDLE.
  - set timeout_err and done, and clear busy.
  - for a read, load IND_RDATA with 64'hFFFF_FFFF_FFFF_FFFF.
REQ-023 SHALL treat tgt_ack arriving in the expiry cycle as a normal completion, with no timeout_err.
REQ-024 SHALL handle IND_CMD writes with both bits set or neither set as follows: no operation, state unchanged, cmd_err sets.
REQ-025 SHALL, in REQ, ignore writes to IND_CMD, IND_ADDR and IND_WDATA and set cmd_err; SCRATCHPAD stays writable.
REQ-026 SHALL make STAT bits 2 and 3 write-1-to-clear; STAT bits 0 and 1 are read-only.
REQ-027 SHALL drive tgt_req only from a flop; no combinational path from tgt_ack to tgt_req.

Reset
REQ-028 SHALL, while rst is high, drive csr_rdata 0, csr_rvalid 0, tgt_req 0, tgt_we 0, tgt_addr 0 and tgt_wdata 0.
REQ-029 SHALL reset SCRATCHPAD, IND_ADDR, IND_WDATA, IND_RDATA, STAT and the timeout counter to 0, and the FSM to IDLE.
REQ-030 SHALL, on rst asserted in REQ, drop tgt_req the cycle after rst is sampled high, with no done or error recorded; a later stale tgt_ack is ignored.

Verification
REQ-031 SHALL cover: read 0x000 -> csr_rvalid next cycle, csr_rdata = 64'h3_00000_001000_0020; write 0x008 = 64'hDEAD_BEEF_0123_4567, read back -> same value; read 0xFF8 -> 0.
REQ-032 SHALL cover: IND_ADDR = 0x00010, IND_CMD = 1, tgt_ack 3 cycles after tgt_req with tgt_rdata = 64'hA5A5 -> tgt_we = 0, tgt_addr = 0x00010, IND_RDATA = 64'hA5A5, STAT = 4'b0010.
REQ-033 SHALL cover: IND_WDATA = 64'h55, IND_CMD = 2, no ack -> tgt_req high exactly TIMEOUT cycles, then STAT = 4'b0110; write STAT = 4'b0100 -> STAT = 4'b0010.
REQ-034 SHALL cover: IND_CMD = 3 in IDLE -> no tgt_req, STAT = 4'b1000; in REQ, write IND_ADDR = 0x3 -> tgt_addr unchanged, cmd_err = 1.
REQ-035 SHALL cover: rst pulsed 2 cycles into a pending read, then tgt_ack -> tgt_req 0, STAT = 0, IND_RDATA = 0.
REQ-036 SHALL cover: tgt_ack in the exact timeout-expiry cycle -> done = 1, timeout_err = 0, IND_RDATA = tgt_rdata.
